seg_scan_driver: RTL and testbench

- Drives an 8-digit, common-anode, time-multiplexed seven-segment display from the 32-bit value selected by the display mux (chose_out).
- Shows one hex nibble per digit and scans digits at a divided rate.
- Snapshots the input once per full frame so a changing counter (PC, cycle count) never tears mid-frame.
- Sits between the display-select mux and the board pins.

---
 rtl/seg_scan_driver.sv | 121 ++++++++++++
 tb/tb_seg_scan_driver.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Eight-digit common-anode seven-segment scanner. Shows one hex nibble per digit,
// with the 32-bit value captured once per frame so the display never tears.
module seg_scan_driver #(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data,
    input  logic        blank_lz,
    input  logic [7:0]  dp_en,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] div_cnt_reg, div_cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic [31:0]      shadow_reg;
    logic [7:0]       dp_sh_reg;
    logic             load_pend_reg;
    logic [7:0]       an_reg, an_next;
    logic [6:0]       seg_reg, seg_next;
    logic             dp_reg, dp_next;
    logic             frame_done_reg;

    logic             tick;
    logic             frame_wrap;
    logic             load;
    logic [7:0]       nib_nz;
    logic [2:0]       msd;
    logic [3:0]       cur_nib;
    logic             blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nz
            assign nib_nz[gi] = |shadow_reg[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        tick         = (div_cnt_reg == DIV_LAST);
        frame_wrap   = tick && (idx_reg == 3'd7);
        // The very first cycle after reset also loads, so a frame is never shown stale.
        load         = load_pend_reg || frame_wrap;
        div_cnt_next = tick ? '0 : div_cnt_reg + CNT_W'(1);
        idx_next     = tick ? idx_reg + 3'd1 : idx_reg;

        msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (nib_nz[i]) msd = 3'(i);
        end

        cur_nib = shadow_reg[{idx_reg, 2'b00} +: 4];
        // msd is 0 for an all-zero value, so digit 0 is never blanked.
        blank   = blank_lz && (idx_reg > msd);

        an_next  = blank ? 8'hFF : ~(8'b1 << idx_reg);
        seg_next = blank ? 7'h7F : seg_decode(cur_nib);
        dp_next  = blank ? 1'b1  : ~dp_sh_reg[idx_reg];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt_reg    <= '0;
            idx_reg        <= 3'd0;
            shadow_reg     <= 32'd0;
            dp_sh_reg      <= 8'd0;
            load_pend_reg  <= 1'b1;
            an_reg         <= 8'hFF;
            seg_reg        <= 7'h7F;
            dp_reg         <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            div_cnt_reg    <= div_cnt_next;
            idx_reg        <= idx_next;
            load_pend_reg  <= 1'b0;
            frame_done_reg <= load;
            if (load) begin
                shadow_reg <= data;
                dp_sh_reg  <= dp_en;
            end
            an_reg  <= an_next;
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver; expected outputs come from a time-based
// model: digit position and snapshot instants are derived from cycles since reset release.
module tb_seg_scan_driver;

    localparam int SD    = 4;
    localparam int FRAME = 8 * SD;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data;
    logic        blank_lz;
    logic [7:0]  dp_en;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_driver #(.SCAN_DIV(SD), .CNT_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .blank_lz   (blank_lz),
        .dp_en      (dp_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: cycles elapsed since reset release and the frame value on display.
    int          cnt;
    logic [31:0] sh_m;
    logic [7:0]  dpsh_m;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_fd;

    function automatic int msd_of(input logic [31:0] v);
        for (int i = 7; i > 0; i--) begin
            if (v[4*i +: 4] != 4'd0) return i;
        end
        return 0;
    endfunction

    function automatic int cur_idx();
        return (cnt / SD) % 8;
    endfunction

    task automatic cycle();
        int  idx;
        bit  blank;
        bit  load;
        @(posedge clk);
        if (!reset) begin
            exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
            cnt = 0; sh_m = 32'd0; dpsh_m = 8'd0;
        end else begin
            idx     = cur_idx();
            blank   = blank_lz && (idx > msd_of(sh_m));
            exp_an  = blank ? 8'hFF : ~(8'd1 << idx);
            exp_seg = blank ? 7'h7F : dec_tbl[sh_m[4*idx +: 4]];
            exp_dp  = blank ? 1'b1  : ~dpsh_m[idx];
            load    = (cnt == 0) || (cnt % FRAME == FRAME - 1);
            exp_fd  = load;
            if (load) begin
                sh_m   = data;
                dpsh_m = dp_en;
            end
            cnt++;
        end
        #1;
        $display("cyc reset=%0b data=%08h blz=%0b dpen=%02h -> an=%02h seg=%02h dp=%0b fd=%0b",
                 reset, data, blank_lz, dp_en, an, seg, dp, frame_done);
        check("an", 32'(an), 32'(exp_an));
        check("seg", 32'(seg), 32'(exp_seg));
        check("dp", 32'(dp), 32'(exp_dp));
        check("frame_done", 32'(frame_done), 32'(exp_fd));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset = 1'b0; data = 32'h12345678; blank_lz = 1'b0; dp_en = 8'h00;
        cnt = 0; sh_m = 32'd0; dpsh_m = 8'd0;
        run(3);
        reset = 1'b1;
        cycle();
        data = 32'h89ABCDEF;
        run(70);

        // Switch the value while mid-frame; the model keeps the old snapshot until wrap.
        data = 32'h00000001;
        run(FRAME);
        run(3 * SD);
        data = 32'hFFFFFFFF;
        run(FRAME);

        blank_lz = 1'b1; dp_en = 8'b0000_0100;
        data = 32'h00000A05;
        run(2 * FRAME);
        data = 32'h00000000;
        run(2 * FRAME);
        data = 32'h00000305;
        run(2 * FRAME);

        // Directed mid-scan reset while digit 5 is being shown.
        for (int i = 0; i < 2 * FRAME && cur_idx() != 5; i++) cycle();
        check("reached_idx5", 32'(cur_idx()), 32'd5);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        data = 32'h0BAD0C0D;
        run(2 * FRAME);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0)
                data = $urandom >> (4 * $urandom_range(0, 8));
            if ($urandom_range(0, 39) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 39) == 0) dp_en = 8'($urandom);
            reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            cycle();
            if (!reset) begin
                run($urandom_range(0, 2));
                reset = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
